blk_frame_sequencer: RTL and testbench

- Frame-level controller for the falling-tile datapath: the per-slot coordinate registers, the random spawn generator and the tile draw path.
- Once per frame tick it runs a fixed sequence:
  - erase every block slot;
  - pulse a move step into the coordinate counters;
  - on spawn frames, capture a random coordinate and load it into the next slot (round-robin);
  - redraw every slot.
- It owns slot selection, per-pixel tile offsets and the VGA plot strobe, so the draw path only adds offsets and muxes colour.

---
 rtl/blk_frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_blk_frame_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_frame_sequencer.sv
// Frame sequencer for the falling-tile datapath. Each frame tick it erases every slot,
// steps the coordinate counters, optionally spawns into the next slot, then redraws.
module blk_frame_sequencer #(
  parameter int unsigned NUM_BLK      = 10,
  parameter int unsigned TILE         = 20,
  parameter int unsigned FRAME_TICKS  = 833333,
  parameter int unsigned SPAWN_FRAMES = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic [1:0]         dir,
  output logic [1:0]         dir_q,
  output logic               move_en,
  output logic               capture,
  output logic [NUM_BLK-1:0] ld_blk,
  output logic [3:0]         slot_sel,
  output logic [4:0]         off_x,
  output logic [4:0]         off_y,
  output logic               erase,
  output logic               plot,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned FCW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned SCW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_TICKS - 1);
  localparam logic [SCW-1:0] SPAWN_LAST = SCW'(SPAWN_FRAMES - 1);
  localparam logic [4:0]     TILE_LAST  = 5'(TILE - 1);
  localparam logic [3:0]     SLOT_LAST  = 4'(NUM_BLK - 1);

  typedef enum logic [2:0] {
    StIdle, StWait, StErase, StMove, StSpawnCap, StSpawnWait, StSpawnLoad, StDraw
  } state_e;

  state_e             state_q, state_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic               pending_q, pending_d;
  logic [SCW-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic [3:0]         ptr_q, ptr_d;
  logic               hold_q, hold_d;
  logic [3:0]         slot_q, slot_d;
  logic [4:0]         offx_q, offx_d;
  logic [4:0]         offy_q, offy_d;
  logic [1:0]         dir_lat_q, dir_lat_d;
  logic               plot_q, plot_d;
  logic               erase_q, erase_d;
  logic               move_en_q, move_en_d;
  logic               capture_q, capture_d;
  logic [NUM_BLK-1:0] ld_blk_q, ld_blk_d;

  logic tick;
  logic scan_last;
  logic consume;
  logic spawn_now;

  always_comb begin
    tick      = (state_q != StIdle) && (frame_cnt_q == FRAME_LAST);
    scan_last = (slot_q == SLOT_LAST) && (offy_q == TILE_LAST) && (offx_q == TILE_LAST);
    consume   = (state_q == StWait) && (pending_q || tick);
    spawn_now = (spawn_cnt_q == SPAWN_LAST);
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start) state_d = StWait;
      StWait:      if (consume) state_d = StErase;
      StErase:     if (scan_last) state_d = StMove;
      StMove:      state_d = spawn_now ? StSpawnCap : StDraw;
      StSpawnCap:  state_d = StSpawnWait;
      StSpawnWait: if (hold_q) state_d = StSpawnLoad;
      StSpawnLoad: state_d = StDraw;
      StDraw:      if (scan_last) state_d = halt ? StIdle : StWait;
      default:     state_d = StIdle;
    endcase
  end

  // Frame timing: counter, pending tick and dropped-tick detection
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    if (state_q == StIdle || state_d == StIdle) begin
      frame_cnt_d = '0;
      pending_d   = 1'b0;
    end else begin
      frame_cnt_d = tick ? '0 : frame_cnt_q + FCW'(1);
      if (consume) begin
        // A tick landing on the consuming cycle re-arms rather than being dropped.
        pending_d = pending_q && tick;
      end else if (tick) begin
        pending_d = 1'b1;
      end
    end
  end

  assign overrun = tick && pending_q && (state_q != StWait);

  // Scan position, spawn bookkeeping and direction latch
  always_comb begin
    slot_d      = slot_q;
    offx_d      = offx_q;
    offy_d      = offy_q;
    spawn_cnt_d = spawn_cnt_q;
    ptr_d       = ptr_q;
    hold_d      = (state_q == StSpawnWait) && !hold_q;
    dir_lat_d   = dir_lat_q;
    if (consume) begin
      slot_d    = '0;
      offx_d    = '0;
      offy_d    = '0;
      dir_lat_d = dir;
    end else if (state_q == StErase || state_q == StDraw) begin
      // Full wrap on the last pixel leaves the scan at zero for the next pass.
      if (offx_q == TILE_LAST) begin
        offx_d = '0;
        if (offy_q == TILE_LAST) begin
          offy_d = '0;
          slot_d = (slot_q == SLOT_LAST) ? 4'd0 : slot_q + 4'd1;
        end else begin
          offy_d = offy_q + 5'd1;
        end
      end else begin
        offx_d = offx_q + 5'd1;
      end
    end
    if (state_q == StMove) begin
      spawn_cnt_d = spawn_now ? '0 : spawn_cnt_q + SCW'(1);
    end
    if (state_q == StSpawnLoad) begin
      ptr_d = (ptr_q == SLOT_LAST) ? 4'd0 : ptr_q + 4'd1;
    end
  end

  // Strobes are registered from the next state so they align with the state they belong to.
  always_comb begin
    plot_d    = (state_d == StErase) || (state_d == StDraw);
    erase_d   = (state_d == StErase);
    move_en_d = (state_d == StMove);
    capture_d = (state_d == StSpawnCap);
    ld_blk_d  = (state_d == StSpawnLoad) ? (NUM_BLK'(1) << ptr_q) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      spawn_cnt_q <= '0;
      ptr_q       <= '0;
      hold_q      <= 1'b0;
      slot_q      <= '0;
      offx_q      <= '0;
      offy_q      <= '0;
      dir_lat_q   <= '0;
      plot_q      <= 1'b0;
      erase_q     <= 1'b0;
      move_en_q   <= 1'b0;
      capture_q   <= 1'b0;
      ld_blk_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      spawn_cnt_q <= spawn_cnt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      slot_q      <= slot_d;
      offx_q      <= offx_d;
      offy_q      <= offy_d;
      dir_lat_q   <= dir_lat_d;
      plot_q      <= plot_d;
      erase_q     <= erase_d;
      move_en_q   <= move_en_d;
      capture_q   <= capture_d;
      ld_blk_q    <= ld_blk_d;
    end
  end

  assign dir_q    = dir_lat_q;
  assign move_en  = move_en_q;
  assign capture  = capture_q;
  assign ld_blk   = ld_blk_q;
  assign slot_sel = slot_q;
  assign off_x    = offx_q;
  assign off_y    = offy_q;
  assign erase    = erase_q;
  assign plot     = plot_q;
  assign busy     = (state_q != StIdle) && (state_q != StWait);

endmodule

// File: tb/tb_blk_frame_sequencer.sv
// Bench for blk_frame_sequencer: a slow-tick instance (A) and a fast-tick instance (B),
// both checked cycle by cycle against an expected-activity scoreboard.
module tb_blk_frame_sequencer;

  localparam int unsigned NB = 3;

  typedef struct packed {
    logic       plot;
    logic       erase;
    logic [3:0] slot;
    logic [4:0] oy;
    logic [4:0] ox;
    logic       mv;
    logic       cap;
    logic [2:0] ld;
    logic [1:0] dir;
  } rec_t;

  typedef struct {
    logic [1:0] dir;
    bit         spawn;
    logic [2:0] ld;
    bit         halt;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, halt_a, mv_a, cap_a, er_a, pl_a, busy_a, ov_a;
  logic [1:0]    dir_a, dirq_a;
  logic [NB-1:0] ld_a;
  logic [3:0]    slot_a;
  logic [4:0]    ox_a, oy_a;

  logic          rst_b, start_b, halt_b, mv_b, cap_b, er_b, pl_b, busy_b, ov_b;
  logic [1:0]    dir_b, dirq_b;
  logic [NB-1:0] ld_b;
  logic [3:0]    slot_b;
  logic [4:0]    ox_b, oy_b;

  blk_frame_sequencer #(.NUM_BLK(NB), .TILE(2), .FRAME_TICKS(40), .SPAWN_FRAMES(2)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .halt(halt_a), .dir(dir_a), .dir_q(dirq_a),
    .move_en(mv_a), .capture(cap_a), .ld_blk(ld_a), .slot_sel(slot_a), .off_x(ox_a),
    .off_y(oy_a), .erase(er_a), .plot(pl_a), .busy(busy_a), .overrun(ov_a)
  );

  blk_frame_sequencer #(.NUM_BLK(NB), .TILE(2), .FRAME_TICKS(10), .SPAWN_FRAMES(2)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .halt(halt_b), .dir(dir_b), .dir_q(dirq_b),
    .move_en(mv_b), .capture(cap_b), .ld_blk(ld_b), .slot_sel(slot_b), .off_x(ox_b),
    .off_y(oy_b), .erase(er_b), .plot(pl_b), .busy(busy_b), .overrun(ov_b)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   t0_a     = 0;
  int   t0_b     = 0;
  bit   mon_on   = 1'b0;
  bit   b_on     = 1'b0;
  bit   busy_pa  = 1'b0;
  bit   busy_pb  = 1'b0;
  int   ov_cnt_b = 0;
  rec_t exp_a[$];
  rec_t exp_b[$];
  int   qs_a[$];
  int   qs_b[$];
  frame_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name, input string act,
                                input string req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endfunction

  function automatic string rec_str(input rec_t r);
    return $sformatf("plot=%b erase=%b slot=%0d y=%0d x=%0d mv=%b cap=%b ld=%b dir=%b",
                     r.plot, r.erase, r.slot, r.oy, r.ox, r.mv, r.cap, r.ld, r.dir);
  endfunction

  function automatic void push_rec(input bit b, input rec_t r);
    if (b) exp_b.push_back(r);
    else exp_a.push_back(r);
  endfunction

  // One frame of busy-cycle activity: erase scan, move, optional spawn, draw scan.
  function automatic void push_frame(input bit b, input logic [1:0] d, input bit spawn,
                                     input logic [2:0] ld);
    rec_t r;
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 3; s++)
        for (int y = 0; y < 2; y++)
          for (int x = 0; x < 2; x++) begin
            r = '0; r.plot = 1'b1; r.erase = (pass == 0); r.slot = 4'(s);
            r.oy = 5'(y); r.ox = 5'(x); r.dir = d;
            push_rec(b, r);
          end
      if (pass == 0) begin
        r = '0; r.mv = 1'b1; r.dir = d; push_rec(b, r);
        if (spawn) begin
          r = '0; r.cap = 1'b1; r.dir = d; push_rec(b, r);
          r = '0; r.dir = d; push_rec(b, r); push_rec(b, r);
          r.ld = ld; push_rec(b, r);
        end
      end
    end
  endfunction

  function automatic bit ov_expected(input int rel);
    return rel inside {29, 49, 59, 79, 89, 109, 119};
  endfunction

  task automatic wait_le(input bit b, input int lim, input string what);
    int sz;
    sz = 0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      sz = b ? exp_b.size() : exp_a.size();
      if (sz <= lim) return;
    end
    check(1'b0, what, $sformatf("queue size %0d", sz), $sformatf("<= %0d", lim));
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (b) begin start_b = 1'b0; t0_b = cyc; b_on = 1'b1; end
    else begin start_a = 1'b0; t0_a = cyc; end
  endtask

  always @(negedge clk) begin
    rec_t act, e;
    int   s;
    if (mon_on) begin
      act = '{plot: pl_a, erase: er_a, slot: slot_a, oy: oy_a, ox: ox_a, mv: mv_a,
              cap: cap_a, ld: ld_a, dir: dirq_a};
      if (busy_a) begin
        if (exp_a.size() == 0) check(1'b0, "a_unexpected_busy", rec_str(act), "idle");
        else begin
          e = exp_a.pop_front();
          check(act === e, "a_seq", rec_str(act), rec_str(e));
        end
        if (!busy_pa && qs_a.size() > 0) begin
          s = qs_a.pop_front();
          check(cyc - t0_a == s, "a_frame_start", $sformatf("%0d", cyc - t0_a),
                $sformatf("%0d", s));
        end
      end else begin
        act.dir = 2'b00;
        check(act === '0, "a_quiet", rec_str(act), rec_str('0));
      end
      check(ov_a === 1'b0, "a_overrun", $sformatf("%b", ov_a), "0");
      busy_pa = busy_a;
    end
  end

  always @(negedge clk) begin
    rec_t act, e;
    int   s;
    bit   eov;
    if (mon_on) begin
      act = '{plot: pl_b, erase: er_b, slot: slot_b, oy: oy_b, ox: ox_b, mv: mv_b,
              cap: cap_b, ld: ld_b, dir: dirq_b};
      if (busy_b) begin
        if (exp_b.size() == 0) check(1'b0, "b_unexpected_busy", rec_str(act), "idle");
        else begin
          e = exp_b.pop_front();
          check(act === e, "b_seq", rec_str(act), rec_str(e));
        end
        if (!busy_pb && qs_b.size() > 0) begin
          s = qs_b.pop_front();
          check(cyc - t0_b == s, "b_frame_start", $sformatf("%0d", cyc - t0_b),
                $sformatf("%0d", s));
        end
      end else begin
        act.dir = 2'b00;
        check(act === '0, "b_quiet", rec_str(act), rec_str('0));
      end
      eov = b_on && ov_expected(cyc - t0_b);
      check(ov_b === eov, "b_overrun", $sformatf("%b at %0d", ov_b, cyc - t0_b),
            $sformatf("%b", eov));
      if (ov_b === 1'b1) ov_cnt_b++;
      busy_pb = busy_b;
    end
  end

  initial begin
    int len;
    tbl[0] = '{2'b11, 1'b0, 3'b000, 1'b0};
    tbl[1] = '{2'b00, 1'b1, 3'b001, 1'b0};
    tbl[2] = '{2'b01, 1'b0, 3'b000, 1'b0};
    tbl[3] = '{2'b10, 1'b1, 3'b010, 1'b0};
    tbl[4] = '{2'b11, 1'b0, 3'b000, 1'b0};
    tbl[5] = '{2'b01, 1'b1, 3'b100, 1'b0};
    tbl[6] = '{2'b10, 1'b0, 3'b000, 1'b0};
    tbl[7] = '{2'b00, 1'b1, 3'b001, 1'b1};

    rst_a = 1'b0; start_a = 1'b0; halt_a = 1'b0; dir_a = 2'b00;
    rst_b = 1'b0; start_b = 1'b0; halt_b = 1'b0; dir_b = 2'b01;
    @(posedge clk); #1 mon_on = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1; rst_b = 1'b1;
    check({pl_a, er_a, mv_a, cap_a, ld_a, busy_a, ov_a, dirq_a, slot_a, ox_a, oy_a} === '0,
          "a_reset_outputs", "nonzero", "all zero");
    check({pl_b, er_b, mv_b, cap_b, ld_b, busy_b, ov_b, dirq_b, slot_b, ox_b, oy_b} === '0,
          "b_reset_outputs", "nonzero", "all zero");
    repeat (100) @(posedge clk);

    // Eight frames on A: spawn every other frame, pointer wrap, dir changed mid-draw, halt last.
    dir_a = tbl[0].dir;
    for (int i = 0; i < 8; i++) begin
      push_frame(1'b0, tbl[i].dir, tbl[i].spawn, tbl[i].ld);
      qs_a.push_back(40 * (i + 1));
      if (i == 0) pulse_start(1'b0);
      len = tbl[i].spawn ? 29 : 25;
      if (tbl[i].halt) begin
        wait_le(1'b0, len - 2, "a_halt_point");
        halt_a = 1'b1;
      end
      wait_le(1'b0, 6, "a_reach_draw");
      if (i < 7) dir_a = tbl[i + 1].dir;
      wait_le(1'b0, 0, "a_frame_done");
    end
    repeat (60) @(posedge clk);
    #1 check(busy_a === 1'b0, "a_idle_after_halt", $sformatf("%b", busy_a), "0");
    halt_a = 1'b0;

    // B: ticks faster than the sequence, so pending forces back-to-back frames.
    push_frame(1'b1, 2'b01, 1'b0, 3'b000);
    push_frame(1'b1, 2'b01, 1'b1, 3'b001);
    push_frame(1'b1, 2'b01, 1'b0, 3'b000);
    push_frame(1'b1, 2'b01, 1'b1, 3'b010);
    qs_b.push_back(10); qs_b.push_back(36); qs_b.push_back(66); qs_b.push_back(92);
    pulse_start(1'b1);
    wait_le(1'b1, 20, "b_halt_point");
    halt_b = 1'b1;
    wait_le(1'b1, 0, "b_frames_done");
    repeat (40) @(posedge clk);
    #1 check(busy_b === 1'b0, "b_idle_after_halt", $sformatf("%b", busy_b), "0");
    check(ov_cnt_b == 7, "b_overrun_count", $sformatf("%0d", ov_cnt_b), "7");
    check(qs_b.size() == 0, "b_all_frames_started", $sformatf("%0d left", qs_b.size()), "0");
    halt_b = 1'b0;

    // A: reset asserted mid-draw aborts the frame.
    dir_a = 2'b10;
    push_frame(1'b0, 2'b10, 1'b0, 3'b000);
    qs_a.push_back(40);
    pulse_start(1'b0);
    wait_le(1'b0, 5, "a_reach_draw_before_reset");
    rst_a = 1'b0;
    @(posedge clk); #1;
    exp_a.delete();
    qs_a.delete();
    check(pl_a === 1'b0 && busy_a === 1'b0, "a_reset_mid_draw",
          $sformatf("plot=%b busy=%b", pl_a, busy_a), "plot=0 busy=0");
    check(dirq_a === 2'b00, "a_reset_dir_q", $sformatf("%b", dirq_a), "00");
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    repeat (60) @(posedge clk);
    #1 check(busy_a === 1'b0, "a_idle_after_reset", $sformatf("%b", busy_a), "0");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
